// File: rtl/reg_bus_initiator.sv
// reg_bus_initiator
//   Register-bus initiator. Converts a valid/ready command stream into
//   single-beat transactions on the peripheral register bus. Supports
//   read, write, and atomic read-modify-write set-bits and clear-bits.
//   Responses return on a valid/ready channel with an error flag.
//
// Ports
//   mclk, h_reset_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_op                     00 read, 01 write, 10 set-bits, 11 clear-bits
//   cmd_addr/cmd_wdata/cmd_be  address, write data or RMW mask, byte enables
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata/rsp_err          read data or written value; timeout flag
//   reg_cs/reg_wr/reg_addr/reg_wdata/reg_be   registered bus request
//   reg_rdata/reg_ack          responder data and one-cycle acknowledge
//   cfg_tmo                    timeout in cs-high cycles, 0 = wait forever
//   busy                       initiator not idle
//
// Build option
//   REG_BUS_TIMEOUT_EN : enables the cs-high timeout. When it is undefined,
//   cfg_tmo is ignored and rsp_err stays 0.
module reg_bus_initiator #(
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int TMO_W = 8
) (
  input  logic              mclk,
  input  logic              h_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [DW-1:0]     cmd_wdata,
  input  logic [DW/8-1:0]   cmd_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              reg_cs,
  output logic              reg_wr,
  output logic [AW-1:0]     reg_addr,
  output logic [DW-1:0]     reg_wdata,
  output logic [DW/8-1:0]   reg_be,
  input  logic [DW-1:0]     reg_rdata,
  input  logic              reg_ack,
  input  logic [TMO_W-1:0]  cfg_tmo,
  output logic              busy
);

  localparam int BW = DW / 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_RSP  = 3'd4;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;

  logic [2:0]    state;
  logic [1:0]    op_q;
  logic [DW-1:0] data_q;   // RMW mask until the read returns, then the new value
  logic [BW-1:0] be_q;
  logic [DW-1:0] rmw_val;
  logic          tmo_hit;

  assign cmd_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RSP);
  assign busy      = (state != S_IDLE);

  // op_q[0] distinguishes clear-bits (1) from set-bits (0) for RMW ops
  always_comb begin
    rmw_val = op_q[0] ? (reg_rdata & ~data_q) : (reg_rdata | data_q);
  end

`ifdef REG_BUS_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W:0]   cnt_nxt;

  // tmo_cnt holds completed cs-high cycles; cnt_nxt is the current cycle's
  // ordinal, so expiry fires on the cfg_tmo-th cs-high cycle.
  assign cnt_nxt = {1'b0, tmo_cnt} + {{TMO_W{1'b0}}, 1'b1};
  assign tmo_hit = (cfg_tmo != '0) && (cnt_nxt >= {1'b0, cfg_tmo});

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      tmo_cnt <= '0;
    end else if ((state == S_IDLE) || (state == S_GAP)) begin
      tmo_cnt <= '0;
    end else if ((state == S_RD) || (state == S_WR)) begin
      tmo_cnt <= cnt_nxt[TMO_W-1:0];
    end
  end
`else
  logic unused_cfg_tmo;
  assign unused_cfg_tmo = ^cfg_tmo;
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      data_q    <= '0;
      be_q      <= '0;
      reg_cs    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= cmd_op;
            data_q   <= cmd_wdata;
            be_q     <= cmd_be;
            reg_addr <= cmd_addr;
            reg_cs   <= 1'b1;
            rsp_err  <= 1'b0;
            if (cmd_op == OP_WR) begin
              reg_wr    <= 1'b1;
              reg_wdata <= cmd_wdata;
              reg_be    <= cmd_be;
              state     <= S_WR;
            end else begin
              reg_wr <= 1'b0;
              reg_be <= '1;
              state  <= S_RD;
            end
          end
        end
        S_RD: begin
          // An ack on the expiry cycle takes priority over the timeout
          if (reg_ack) begin
            reg_cs <= 1'b0;
            if (op_q == OP_RD) begin
              rsp_rdata <= reg_rdata;
              state     <= S_RSP;
            end else begin
              data_q <= rmw_val;
              state  <= S_GAP;
            end
          end else if (tmo_hit) begin
            reg_cs    <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_RSP;
          end
        end
        S_GAP: begin
          reg_cs    <= 1'b1;
          reg_wr    <= 1'b1;
          reg_wdata <= data_q;
          reg_be    <= be_q;
          state     <= S_WR;
        end
        S_WR: begin
          if (reg_ack) begin
            reg_cs    <= 1'b0;
            rsp_rdata <= reg_wdata;
            state     <= S_RSP;
          end else if (tmo_hit) begin
            reg_cs    <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= S_RSP;
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state  <= S_IDLE;
          reg_cs <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_initiator.sv
// tb_reg_bus_initiator
//   Directed and randomized bench for reg_bus_initiator. A behavioural
//   responder with configurable ack delay serves the bus; a register-array
//   model predicts responses, latencies, cs-high counts and write beats.
module tb_reg_bus_initiator;

  logic        mclk = 1'b0;
  logic        h_reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        reg_cs;
  logic        reg_wr;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic [31:0] reg_rdata;
  logic        reg_ack;
  logic [7:0]  cfg_tmo = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // responder state
  logic [31:0] bus_mem [16];
  logic [31:0] model_mem [16];
  logic        resp_ack;
  logic [31:0] resp_rdata;
  logic        stray_ack = 1'b0;
  logic        load_req = 1'b0;
  int          ack_dly = 1;
  int          cs_seen;
  int          beats;
  logic [3:0]  lb_addr;
  logic [31:0] lb_data;
  logic [3:0]  lb_be;

  assign reg_ack   = resp_ack | stray_ack;
  assign reg_rdata = resp_rdata;

  reg_bus_initiator #(.AW(4), .DW(32), .TMO_W(8)) dut (
    .mclk(mclk), .h_reset_n(h_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata),
    .reg_ack(reg_ack), .cfg_tmo(cfg_tmo), .busy(busy)
  );

  always #5 mclk = ~mclk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = be[i] ? n[i*8 +: 8] : o[i*8 +: 8];
    return r;
  endfunction

  // Responder: acks on the ack_dly-th sampled cs-high cycle (0 = never).
  // A write phase is recorded when its cs is first seen.
  always @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      cs_seen  <= 0;
      resp_ack <= 1'b0;
    end else if (load_req) begin
      for (int i = 0; i < 16; i++) bus_mem[i] <= model_mem[i];
    end else if (!reg_cs || resp_ack) begin
      cs_seen  <= 0;
      resp_ack <= 1'b0;
    end else begin
      cs_seen <= cs_seen + 1;
      if (reg_wr && cs_seen == 0) begin
        beats   <= beats + 1;
        lb_addr <= reg_addr;
        lb_data <= reg_wdata;
        lb_be   <= reg_be;
      end
      if (ack_dly != 0 && cs_seen + 1 >= ack_dly) begin
        resp_ack <= 1'b1;
        if (reg_wr) bus_mem[reg_addr] <= merge(bus_mem[reg_addr], reg_wdata, reg_be);
        else        resp_rdata <= bus_mem[reg_addr];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge mclk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] a,
                       input logic [31:0] w, input logic [3:0] be);
    int k;
    k = 0;
    while (!cmd_ready && k < 20) begin step; k++; end
    check("cmd_ready_before_issue", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = w; cmd_be = be;
    step;
    cmd_valid = 1'b0;
  endtask

  // d: responder ack delay (0 = never), bp: rsp_ready low cycles,
  // tmo: cfg_tmo value (0 when the timeout build option is off)
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [31:0] w,
                         input logic [3:0] be, input int d, input int bp,
                         input bit stray_gap, input int tmo);
    logic [31:0] old, nv, exp_rd;
    int exp_lat, exp_cs, k, cs_hi, beats0;
    bit tmo_hit, gap_ok;
    logic wr0;
    logic [3:0] be0;
    ack_dly = d;
    cfg_tmo = tmo[7:0];
    tmo_hit = (tmo != 0) && (d == 0 || d + 1 > tmo);
    old = model_mem[a];
    case (op)
      2'b00: nv = old;
      2'b01: nv = w;
      2'b10: nv = old | w;
      default: nv = old & ~w;
    endcase
    if (tmo_hit) begin
      exp_rd = '0; exp_lat = tmo + 1; exp_cs = tmo;
    end else begin
      exp_rd = nv;
      if (op[1]) begin exp_lat = 2 * d + 4; exp_cs = 2 * d + 2; end
      else       begin exp_lat = d + 2;     exp_cs = d + 1;     end
      if (op != 2'b00) model_mem[a] = merge(old, nv, be);
    end
    beats0 = beats;
    issue(op, a, w, be);
    wr0 = reg_wr; be0 = reg_be;
    k = 0; cs_hi = 0; gap_ok = 1'b1;
    while (!rsp_valid && k < 300) begin
      if (reg_cs) cs_hi++;
      if (op[1] && k == d + 1) gap_ok = !reg_cs && busy;
      stray_ack = stray_gap && op[1] && (k == d + 1);
      step;
      stray_ack = 1'b0;
      k++;
    end
    check("rsp_latency", k + 1, exp_lat);
    check("cs_high_cycles", cs_hi, exp_cs);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, tmo_hit);
    check("first_beat_wr_be", {wr0, be0}, {op == 2'b01, (op == 2'b01) ? be : 4'hF});
    check("write_beats", beats - beats0, (op != 2'b00 && !tmo_hit) ? 1 : 0);
    if (op != 2'b00 && !tmo_hit)
      check("write_beat", {lb_addr, lb_data, lb_be}, {a, nv, be});
    if (op[1] && !tmo_hit) check("gap_cs_low", gap_ok, 1'b1);
    for (int i = 0; i < bp; i++) begin
      stray_ack = (i == 0);  // stray ack while holding a response
      check("bp_hold", {rsp_valid, cmd_ready, reg_cs, rsp_err, rsp_rdata},
            {1'b1, 1'b0, 1'b0, tmo_hit, exp_rd});
      step;
      stray_ack = 1'b0;
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    check("idle_after_rsp", {rsp_valid, cmd_ready, busy, reg_cs}, 4'b0100);
  endtask

  initial begin
    int k, n, d, tmo;
    logic [31:0] v;
    #3;
    check("reset_bus", {reg_cs, reg_wr, reg_addr, reg_wdata, reg_be}, '0);
    check("reset_rsp", {rsp_valid, rsp_err, busy, cmd_ready, rsp_rdata}, {4'b0001, 32'h0});
    @(negedge mclk);
    h_reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin v = $urandom; model_mem[i] = v; end
    model_mem[0] = 32'h0000_00F0;
    load_req = 1'b1;
    step;
    load_req = 1'b0;

    // directed register operations
    run_cmd(2'b01, 4'd3, 32'hA5A5_0F0F, 4'hF, 1, 0, 1'b0, 0);
    run_cmd(2'b00, 4'd0, 32'h0, 4'h0, 1, 0, 1'b0, 0);
    run_cmd(2'b10, 4'd0, 32'h0000_0003, 4'hF, 1, 0, 1'b1, 0);
    run_cmd(2'b11, 4'd0, 32'h0000_00F0, 4'hF, 1, 0, 1'b0, 0);
    run_cmd(2'b00, 4'd3, 32'h0, 4'h0, 1, 4, 1'b0, 0);

    // stray ack while idle
    stray_ack = 1'b1;
    step;
    stray_ack = 1'b0;
    step;
    check("stray_idle", {cmd_ready, busy, reg_cs, rsp_valid}, 4'b1000);

    // no ack with cfg_tmo=0: cs must stay up indefinitely
    ack_dly = 0; cfg_tmo = '0;
    issue(2'b00, 4'd7, 32'h0, 4'h0);
    n = 0;
    repeat (60) begin if (reg_cs) n++; step; end
    check("noack_cs_held", n, 60);
    ack_dly = 1;
    k = 0;
    while (!rsp_valid && k < 20) begin step; k++; end
    check("noack_late_rdata", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, model_mem[7]});
    rsp_ready = 1'b1; step; rsp_ready = 1'b0;

`ifdef REG_BUS_TIMEOUT_EN
    run_cmd(2'b00, 4'd2, 32'h0, 4'hF, 0, 0, 1'b0, 5);
    run_cmd(2'b10, 4'd2, 32'hFFFF_0000, 4'hF, 0, 2, 1'b0, 5);
    run_cmd(2'b01, 4'd4, 32'h1234_5678, 4'h5, 1, 0, 1'b0, 2);
    run_cmd(2'b11, 4'd4, 32'h0000_00FF, 4'hF, 1, 0, 1'b0, 2);
`endif

    // reset asserted during the GAP cycle of an RMW
    ack_dly = 1; cfg_tmo = '0;
    n = beats;
    issue(2'b10, 4'd5, 32'hFFFF_FFFF, 4'hF);
    step; step;
    check("gap_before_reset", {reg_cs, busy}, 2'b01);
    #2 h_reset_n = 1'b0;
    #1;
    check("async_reset_bus", {reg_cs, reg_wr, reg_addr, reg_wdata, reg_be}, '0);
    check("async_reset_rsp", {rsp_valid, rsp_err, busy, cmd_ready, rsp_rdata}, {4'b0001, 32'h0});
    @(negedge mclk);
    h_reset_n = 1'b1;
    k = 0;
    repeat (10) begin if (reg_cs) k++; step; end
    check("post_reset_no_cs", k, 0);
    check("post_reset_no_write", beats - n, 0);
    check("post_reset_ready", cmd_ready, 1'b1);

    // randomized traffic against the register-array model
    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(1, 3);
      tmo = 0;
`ifdef REG_BUS_TIMEOUT_EN
      if ($urandom_range(0, 1) == 1) tmo = d + 1 + $urandom_range(0, 2);
`endif
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), $urandom,
              4'($urandom_range(0, 15)), d, $urandom_range(0, 3), 1'b0, tmo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_bus_initiator.md
# reg_bus_initiator

Register-bus initiator (master) that turns a valid/ready command stream into single-beat transactions on the peripheral register bus (cs/wr/addr/wdata/be, ack/rdata). It sits between a CPU-side or sequencer-side command source and peripheral register blocks such as the GPIO register file. It supports read, write and atomic read-modify-write set-bits and clear-bits operations. Responses return through a valid/ready channel with an error flag.

## Interface
Parameters:
- AW, 4, register address width
- DW, 32, data width; byte enables are DW/8
- TMO_W, 8, timeout counter width

Ports:
- mclk  in  1  clock
- h_reset_n  in  1  reset, asynchronous, active-low; clock mclk
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when high together with cmd_valid
- cmd_op  in  2  00 read, 01 write, 10 RMW set-bits, 11 RMW clear-bits
- cmd_addr  in  AW  register address
- cmd_wdata  in  DW  write data, or bit mask for RMW
- cmd_be  in  DW/8  byte enables for the write beat
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DW  read data, or the value written for write/RMW
- rsp_err  out  1  transaction timed out
- reg_cs  out  1  bus chip select
- reg_wr  out  1  1 write, 0 read
- reg_addr  out  AW  bus address
- reg_wdata  out  DW  bus write data
- reg_be  out  DW/8  bus byte enables
- reg_rdata  in  DW  responder read data, valid with reg_ack
- reg_ack  in  1  one-cycle responder acknowledge
- cfg_tmo  in  TMO_W  timeout in cycles; 0 disables the timeout
- busy  out  1  state not IDLE

## Operation
- States: IDLE, RD, GAP, WR, RSP. All bus outputs are registered.
- cmd_ready = (state==IDLE). rsp_valid = (state==RSP). busy = (state!=IDLE).
- On IDLE with cmd_valid, latch op, addr, wdata and be.
  - Read and RMW ops go to RD with reg_wr=0, reg_be=all-ones.
  - Write ops go to WR with reg_wr=1, reg_wdata=cmd_wdata, reg_be=cmd_be.
- reg_cs is high only in RD and WR. It drops on the edge at which reg_ack is sampled high, so the responder re-arms and no second ack occurs.
- RD on ack:
  - Capture reg_rdata.
  - For a read, rsp_rdata = reg_rdata, then go to RSP.
  - For RMW set, new = rdata | mask. For RMW clear, new = rdata & ~mask. Then go to GAP.
- GAP lasts exactly one cycle with cs low. It then goes to WR with reg_wdata=new and reg_be=cmd_be.
- WR on ack: rsp_rdata = written value, then go to RSP.
- RSP holds rsp_rdata and rsp_err stable until rsp_ready, then returns to IDLE. Accepting a new command in the same cycle is not allowed.
- reg_ack seen while in IDLE, GAP or RSP (late or stray) is ignored.
- reg_addr, reg_wdata and reg_be hold their last values when cs is low.

## Timing
- Reset values: reg_cs, reg_wr, reg_addr, reg_wdata, reg_be, rsp_rdata and rsp_err are 0; rsp_valid 0, busy 0, cmd_ready 1; state IDLE.
- Reset mid-operation aborts immediately and causes no further bus activity.
- Read or write, with the command accepted in cycle 0 and a responder that acks one cycle after cs:
  - cs high in cycles 1-2
  - ack in cycle 2
  - rsp_valid from cycle 3
- RMW:
  - read cs in cycles 1-2
  - GAP in cycle 3
  - write cs in cycles 4-5
  - rsp_valid from cycle 6
- Throughput: at most one command per 4 cycles, or per 7 cycles for RMW, plus any response backpressure.

## Configuration
- REG_BUS_TIMEOUT_EN defined:
  - A counter counts cs-high cycles in RD/WR.
  - If no ack arrives by the cfg_tmo-th cs-high cycle, cs drops, rsp_err=1 and rsp_rdata=0, and the state goes to RSP. An RMW write phase is skipped.
  - An ack in the same cycle as expiry wins, giving a normal completion.
  - The counter clears on every RD/WR entry.
  - cfg_tmo=0 means wait forever.
- REG_BUS_TIMEOUT_EN undefined:
  - No counter; the initiator waits forever.
  - cfg_tmo is ignored and rsp_err is tied 0.

## Test plan
- Write 0xA5A50F0F to addr 3 with be=F: reg_wr=1 with cs in cycles 1-2; rsp_rdata=0xA5A50F0F, rsp_err=0 at cycle 3.
- Read addr 0 with the responder holding 0x000000F0: reg_be=F, reg_wr=0; rsp_rdata=0x000000F0.
- RMW set, mask 0x00000003, on 0x000000F0: cs low in cycle 3; write beat carries 0x000000F3; rsp_rdata=0x000000F3. Then RMW clear, mask 0xF0, gives 0x00000003.
- Timeout (macro on), cfg_tmo=5, responder never acks: cs high exactly 5 cycles; rsp_err=1, rsp_rdata=0; RMW never issues its write. With cfg_tmo=0, cs stays high for 50+ cycles.
- Backpressure, with rsp_ready low for 4 cycles: rsp_valid and rsp_rdata stay stable, cmd_ready stays 0 and cs stays 0; IDLE follows the cycle after rsp_ready.
- Reset asserted during GAP of an RMW: all outputs go to their reset values asynchronously; after release no write beat occurs and cmd_ready=1.
